mul_d_pipe: RTL and testbench
=============================

// Module: mul_D_pipe
// PURPOSE
//  Pipelined 23x23 unsigned multiplier feeding red_D (Barrett reduction, q=8380417).
//  Takes two Dilithium coefficients with a valid/ready handshake.
//  Produces the full 46-bit product, which drives red_D.product_i directly.
//  Carries a user tag and an operand range-error flag alongside each beat.
// PARAMETERS
//  Q      8380417  Dilithium modulus; used only for the operand range check
//  W      23       coefficient width; product width is 2*W
//  TAG_W  8        width of the opaque tag carried with each beat
// PORTS
//  clk_i          in   1      single clock, rising edge
//  rst_i          in   1      synchronous, active-high reset
//  a_i            in   W      operand A (unsigned)
//  b_i            in   W      operand B (unsigned)
//  tag_i          in   TAG_W  tag accompanying a_i/b_i
//  in_valid_i     in   1      upstream beat valid
//  in_ready_o     out  1      block can accept a beat this cycle
//  product_o      out  2*W    a*b, exact and unreduced; connects to red_D.product_i
//  tag_o          out  TAG_W  tag of the beat on product_o
//  range_err_o    out  1      beat had a_i>=Q or b_i>=Q
//  out_valid_o    out  1      product_o/tag_o/range_err_o valid
//  out_ready_i    in   1      downstream accepts the beat
//  busy_o         out  1      at least one pipeline stage holds a valid beat
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge):
//   - All stage valid bits, data, tag and err registers clear to 0.
//   - Next cycle: out_valid_o=0, busy_o=0, product_o=0, tag_o=0, range_err_o=0.
//   - in_ready_o=0 while rst_i=1.
//   - Reset mid-operation silently drops all in-flight beats; no partial output.
//  Transfers:
//   - An input transfer occurs when in_valid_i && in_ready_o.
//   - An output transfer occurs when out_valid_o && out_ready_i.
//   - Once out_valid_o=1, product_o/tag_o/range_err_o hold stable until the output transfer.
//  Pipeline, 3 register stages (S1, S2, S3):
//   - S1: register a, b and tag; err = (a>=Q)|(b>=Q).
//   - S2: split b into b_lo = b[11:0] and b_hi = b[22:12].
//     Register pp_lo = a*b_lo (35b) and pp_hi = a*b_hi (34b).
//   - S3: register product = pp_lo + (pp_hi<<12), truncated to 2*W bits.
//   - S3 drives the outputs.
//  Latency: exactly 3 cycles from input transfer to out_valid_o with no backpressure.
//  Throughput: 1 beat/cycle.
//  Stall rule:
//   - Each stage Sk has a valid bit vk.
//   - Sk loads iff !vk || stage k+1 loads; stage 4 "loads" = out_ready_i.
//   - A stage that does not load holds data, tag, err and vk.
//   - in_ready_o = !rst_i && (S1 loads).
//   - in_ready_o depends combinationally on out_ready_i.
//   - in_ready_o never depends on in_valid_i.
//   - Bubbles compress: an empty stage accepts even when downstream stalls.
//  Boundary conditions:
//   - Full pipe (3 beats) with out_ready_i=0: in_ready_o=0, no beat lost or duplicated.
//   - Full pipe with out_ready_i=1 and in_valid_i=1: one out and one in on the same cycle.
//   - Order is strictly preserved; tag_o follows its own product.
//   - busy_o = v1|v2|v3.
//  Arithmetic:
//   - Out-of-range operands are still multiplied exactly.
//   - range_err_o only flags the beat; the product is not forced.
//   - The product always fits 46 bits, so no overflow case exists.
//   - (Q-1)^2 = 70231372333056 < 2^46.
// TESTING
//  T1 reset: assert rst_i 2 cycles with in_valid_i=1.
//     -> out_valid_o=0, busy_o=0, in_ready_o=0, all outputs 0.
//  T2 latency: a=2, b=3, tag=8'h5A accepted at cycle 0, out_ready_i=1.
//     -> out_valid_o=1 at cycle 3 with product_o=6, tag_o=8'h5A, range_err_o=0.
//  T3 max: a=b=8380416.
//     -> product_o=46'd70231372333056, range_err_o=0.
//     Feed into red_D -> result 1.
//  T4 range: a=8380417, b=1 -> product_o=8380417, range_err_o=1.
//     a=0, b=8388607 -> product_o=0, range_err_o=1.
//  T5 backpressure: stream tags 1..5 back-to-back; out_ready_i=0 for cycles 2..7, then 1.
//     -> in_ready_o=0 once 3 beats are held.
//     -> tags emerge 1,2,3,4,5 exactly once each, with correct products.
//  T6 mid-op reset: 3 beats in flight, pulse rst_i 1 cycle.
//     -> out_valid_o=0 next cycle, nothing emitted.
//     -> a new beat then obeys the T2 latency.

Source files
------------

// File: rtl/mul_d_pipe.sv
// Three-stage 23x23 unsigned multiplier with valid/ready flow control, carrying a tag and
// an operand range-error flag per beat. The 46-bit product feeds red_D.product_i directly.
`timescale 1ns/1ps
module mul_d_pipe #(
   parameter int unsigned Q     = 8380417,
   parameter int unsigned W     = 23,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [2*W-1:0]   product_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             range_err_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   localparam int unsigned LO_W = 12;
   localparam int unsigned HI_W = W - LO_W;
   localparam int unsigned P_W  = 2 * W;
   localparam logic [W-1:0] Q_L = W'(Q);

   // Handshake: a beat moves into a stage when that stage loads; a stage loads when it is
   // empty or its successor loads, and the output stage's successor is out_ready_i.
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [W-1:0]     a1_q, a1_d, b1_q, b1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic             err1_q, err1_d, err2_q, err2_d, err3_q, err3_d;
   logic [W+LO_W-1:0] pp_lo_q, pp_lo_d;
   logic [W+HI_W-1:0] pp_hi_q, pp_hi_d;
   logic [P_W-1:0]   prod3_q, prod3_d;
   logic             ld1, ld2, ld3;

   assign ld3 = !v3_q || out_ready_i;
   assign ld2 = !v2_q || ld3;
   assign ld1 = !v1_q || ld2;

   always_comb begin
      v1_d    = v1_q;
      a1_d    = a1_q;
      b1_d    = b1_q;
      tag1_d  = tag1_q;
      err1_d  = err1_q;
      v2_d    = v2_q;
      pp_lo_d = pp_lo_q;
      pp_hi_d = pp_hi_q;
      tag2_d  = tag2_q;
      err2_d  = err2_q;
      v3_d    = v3_q;
      prod3_d = prod3_q;
      tag3_d  = tag3_q;
      err3_d  = err3_q;

      if (ld1) begin
         v1_d   = in_valid_i;
         a1_d   = a_i;
         b1_d   = b_i;
         tag1_d = tag_i;
         err1_d = (a_i >= Q_L) || (b_i >= Q_L);
      end

      if (ld2) begin
         v2_d    = v1_q;
         pp_lo_d = {{LO_W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q[LO_W-1:0]};
         pp_hi_d = {{HI_W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q[W-1:LO_W]};
         tag2_d  = tag1_q;
         err2_d  = err1_q;
      end

      // The recombined sum never exceeds 2*W bits for W-bit operands.
      if (ld3) begin
         v3_d    = v2_q;
         prod3_d = {{HI_W{1'b0}}, pp_lo_q} + {pp_hi_q, {LO_W{1'b0}}};
         tag3_d  = tag2_q;
         err3_d  = err2_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         tag1_q  <= '0;
         err1_q  <= 1'b0;
         v2_q    <= 1'b0;
         pp_lo_q <= '0;
         pp_hi_q <= '0;
         tag2_q  <= '0;
         err2_q  <= 1'b0;
         v3_q    <= 1'b0;
         prod3_q <= '0;
         tag3_q  <= '0;
         err3_q  <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         tag1_q  <= tag1_d;
         err1_q  <= err1_d;
         v2_q    <= v2_d;
         pp_lo_q <= pp_lo_d;
         pp_hi_q <= pp_hi_d;
         tag2_q  <= tag2_d;
         err2_q  <= err2_d;
         v3_q    <= v3_d;
         prod3_q <= prod3_d;
         tag3_q  <= tag3_d;
         err3_q  <= err3_d;
      end
   end

   assign in_ready_o  = !rst_i && ld1;
   assign product_o   = prod3_q;
   assign tag_o       = tag3_q;
   assign range_err_o = err3_q;
   assign out_valid_o = v3_q;
   assign busy_o      = v1_q || v2_q || v3_q;

endmodule

// File: tb/tb_mul_d_pipe.sv
// Directed bench for mul_d_pipe: reset, latency, arithmetic corners, backpressure and
// mid-operation reset, with an output monitor checking beats against an expected queue.
`timescale 1ns/1ps
module tb_mul_d_pipe;

   localparam int EW = 1 + 8 + 46;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [22:0] a_i, b_i;
   logic [7:0]  tag_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [45:0] product_o;
   logic [7:0]  tag_o;
   logic        range_err_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        busy_o;

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;
   logic [EW-1:0] exp_q[$];

   logic [22:0] va[5], vb[5];
   logic [45:0] vp[5];

   mul_d_pipe dut (
      .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .product_o(product_o),
      .tag_o(tag_o), .range_err_o(range_err_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Offer one beat until accepted (bounded), recording its hand-computed expectation.
   task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [7:0] t,
                       input logic [45:0] p, input logic e);
      logic done;
      done = 1'b0;
      a_i = a;
      b_i = b;
      tag_i = t;
      in_valid_i = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         #1;
         if (in_ready_o) begin
            exp_q.push_back({e, t, p});
            done = 1'b1;
         end
         tick();
      end
      in_valid_i = 1'b0;
      check("send_accept", done, 1);
   endtask

   task automatic lat_beat(input logic [22:0] a, input logic [22:0] b, input logic [7:0] t,
                           input logic [45:0] p, input logic e);
      out_ready_i = 1'b1;
      a_i = a;
      b_i = b;
      tag_i = t;
      in_valid_i = 1'b1;
      #1;
      check("lat_in_ready", in_ready_o, 1);
      exp_q.push_back({e, t, p});
      tick();
      in_valid_i = 1'b0;
      check("lat_cyc1_valid", out_valid_o, 0);
      tick();
      check("lat_cyc2_valid", out_valid_o, 0);
      tick();
      check("lat_cyc3_valid", out_valid_o, 1);
      tick();
   endtask

   // Output monitor: scoreboard pops on each transfer and checks held outputs stay stable.
   initial begin
      logic          hold_pend;
      logic [45:0]   hold_prod;
      logic [7:0]    hold_tag;
      logic          hold_err;
      logic [EW-1:0] e;
      hold_pend = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) begin
               check("hold_valid", out_valid_o, 1);
               check("hold_prod", product_o, hold_prod);
               check("hold_tag", tag_o, hold_tag);
               check("hold_err", range_err_o, hold_err);
            end
            hold_pend = out_valid_o && !out_ready_i;
            hold_prod = product_o;
            hold_tag  = tag_o;
            hold_err  = range_err_o;
            if (out_valid_o && out_ready_i) begin
               n_out++;
               check("out_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("out_prod", product_o, e[45:0]);
                  check("out_tag", tag_o, e[53:46]);
                  check("out_err", range_err_o, e[54]);
               end
            end
         end
      end
   end

   initial begin
      int idx;
      va[0] = 23'd1000;    vb[0] = 23'd1000;    vp[0] = 46'd1000000;
      va[1] = 23'd4096;    vb[1] = 23'd4096;    vp[1] = 46'd16777216;
      va[2] = 23'd8380416; vb[2] = 23'd2;       vp[2] = 46'd16760832;
      va[3] = 23'd123456;  vb[3] = 23'd7890;    vp[3] = 46'd974067840;
      va[4] = 23'd4095;    vb[4] = 23'd4095;    vp[4] = 46'd16769025;

      // T1: reset held two cycles with a valid beat offered
      rst_i = 1'b1;
      in_valid_i = 1'b1;
      a_i = 23'd5;
      b_i = 23'd7;
      tag_i = 8'd3;
      out_ready_i = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready_o, 0);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_product", product_o, 0);
      check("rst_tag", tag_o, 0);
      check("rst_err", range_err_o, 0);
      rst_i = 1'b0;
      in_valid_i = 1'b0;
      tick();
      check("post_rst_busy", busy_o, 0);
      check("post_rst_in_ready", in_ready_o, 1);

      // T2: latency
      lat_beat(23'd2, 23'd3, 8'h5A, 46'd6, 1'b0);

      // T3/T4: arithmetic corners and range flag
      send(23'd8380416, 23'd8380416, 8'h10, 46'd70231372333056, 1'b0);
      send(23'd8380417, 23'd1,       8'h11, 46'd8380417, 1'b1);
      send(23'd0,       23'd8388607, 8'h12, 46'd0, 1'b1);
      send(23'd8380416, 23'd8380417, 8'h13, 46'd70231380713472, 1'b1);
      send(23'd8388607, 23'd8388607, 8'h14, 46'd70368727400449, 1'b1);
      repeat (6) tick();
      check("t4_drained_busy", busy_o, 0);

      // T5: backpressure, out_ready low for cycles 2..7
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         out_ready_i = !(c >= 2 && c <= 7);
         if (idx < 5) begin
            a_i = va[idx];
            b_i = vb[idx];
            tag_i = 8'(idx + 1);
            in_valid_i = 1'b1;
         end else begin
            in_valid_i = 1'b0;
         end
         #1;
         if (c >= 3 && c <= 7) begin
            check("t5_full_in_ready", in_ready_o, 0);
            check("t5_full_busy", busy_o, 1);
         end
         if (c == 8) begin
            check("t5_pass_in_ready", in_ready_o, 1);
            check("t5_pass_out_valid", out_valid_o, 1);
         end
         if (in_valid_i && in_ready_o) begin
            exp_q.push_back({1'b0, 8'(idx + 1), vp[idx]});
            idx++;
         end
         tick();
      end
      in_valid_i = 1'b0;
      check("t5_all_sent", idx, 5);
      check("t5_queue_empty", exp_q.size(), 0);

      // T6: reset with three beats in flight
      out_ready_i = 1'b0;
      send(23'd11, 23'd13, 8'h21, 46'd143, 1'b0);
      send(23'd17, 23'd19, 8'h22, 46'd323, 1'b0);
      send(23'd23, 23'd29, 8'h23, 46'd667, 1'b0);
      check("t6_full_in_ready", in_ready_o, 0);
      idx = n_out;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_q.delete();
      check("t6_out_valid", out_valid_o, 0);
      check("t6_busy", busy_o, 0);
      out_ready_i = 1'b1;
      repeat (5) tick();
      check("t6_nothing_out", n_out, idx);
      lat_beat(23'd7, 23'd9, 8'hC3, 46'd63, 1'b0);

      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_out_count", n_out, 12);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
